// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: clocked EX/MEM pipeline register with valid/ready handshake.
// Holds a head entry (M) that faces the MEM stage. With SKID=1 it also holds a
// second skid entry (S), which makes in_ready_o a pure flop output.
// MemRead_o/MemWrite_o are gated by the head valid bit. The other head
// data/control outputs show whatever the head flops last held.
// Optional feature: define EX_MEM_FWD_EN to add the fwd_valid_o/fwd_rd_o/fwd_data_o
// outputs that feed the EX forwarding unit.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        MEM_i,
  input  logic [DATA_W-1:0] ALUOut_i,
  input  logic [DATA_W-1:0] mux7_i,
  input  logic [REG_W-1:0]  mux8_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        WB_o,
  output logic [DATA_W-1:0] ALUOut_o,
  output logic [DATA_W-1:0] mux7_o,
  output logic [REG_W-1:0]  mux8_o,
  output logic              MemRead_o,
`ifdef EX_MEM_FWD_EN
  output logic              MemWrite_o,
  output logic              fwd_valid_o,
  output logic [REG_W-1:0]  fwd_rd_o,
  output logic [DATA_W-1:0] fwd_data_o
`else
  output logic              MemWrite_o
`endif
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [1:0]        mem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t in_ent;
  ent_t m_q, m_d;
  logic m_vld_q, m_vld_d;
  ent_t s_q;
  logic s_vld_q;
  logic accept, deliver;

  assign in_ent  = '{wb: WB_i, mem: MEM_i, alu: ALUOut_i, st: mux7_i, rd: mux8_i};
  assign accept  = in_valid_i & in_ready_o & ~flush_i;
  assign deliver = m_vld_q & out_ready_i;

  // Head next-state: refill from S first (keeps order), then from the input.
  always_comb begin
    m_d     = m_q;
    m_vld_d = m_vld_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
    end else if (!m_vld_q || deliver) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
      end else if (accept) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end
  end

  // Head entry flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_q     <= '0;
      m_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      ent_t s_d;
      logic s_vld_d;

      // Skid fills only when the head is stuck and an input is accepted;
      // it empties whenever the head moves (its content goes to M).
      always_comb begin
        s_d     = s_q;
        s_vld_d = s_vld_q;
        if (flush_i) begin
          s_vld_d = 1'b0;
        end else if (!m_vld_q || deliver) begin
          s_vld_d = 1'b0;
        end else if (accept) begin
          s_d     = in_ent;
          s_vld_d = 1'b1;
        end
      end

      // Skid entry flops.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          s_q     <= '0;
          s_vld_q <= 1'b0;
        end else begin
          s_q     <= s_d;
          s_vld_q <= s_vld_d;
        end
      end

      assign in_ready_o = ~s_vld_q;
    end else begin : g_noskid
      assign s_q        = '0;
      assign s_vld_q    = 1'b0;
      assign in_ready_o = ~m_vld_q | out_ready_i;
    end
  endgenerate

  assign out_valid_o = m_vld_q;
  assign WB_o        = m_q.wb;
  assign ALUOut_o    = m_q.alu;
  assign mux7_o      = m_q.st;
  assign mux8_o      = m_q.rd;
  assign MemRead_o   = m_q.mem[0] & m_vld_q;
  assign MemWrite_o  = m_q.mem[1] & m_vld_q;

`ifdef EX_MEM_FWD_EN
  // Only plain ALU writebacks to a non-zero register can be forwarded from here.
  assign fwd_valid_o = m_vld_q & m_q.wb[0] & ~m_q.wb[1] & (m_q.rd != '0);
  assign fwd_rd_o    = m_q.rd;
  assign fwd_data_o  = m_q.alu;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Testbench for ex_mem_stage_reg: one SKID=1 and one SKID=0 instance share the
// same stimulus. Each instance is checked against its own queue model of the
// held entries.
module tb_ex_mem_stage_reg;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_v = 1'b0, out_r = 1'b0;
  logic [1:0] wb_i = '0, mem_i = '0;
  logic [31:0] alu_i = '0, st_i = '0;
  logic [4:0] rd_i = '0;

  logic a_ir, a_ov, a_mr, a_mw, b_ir, b_ov, b_mr, b_mw;
  logic [1:0] a_wb, b_wb;
  logic [31:0] a_alu, a_st, b_alu, b_st;
  logic [4:0] a_rd, b_rd;
`ifdef EX_MEM_FWD_EN
  logic a_fv, b_fv;
  logic [4:0] a_frd, b_frd;
  logic [31:0] a_fd, b_fd;
`endif

  int n_chk = 0, n_err = 0;
  ent_t qa[$], qb[$];

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(32), .REG_W(5), .SKID(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_v), .in_ready_o(a_ir),
    .WB_i(wb_i), .MEM_i(mem_i), .ALUOut_i(alu_i), .mux7_i(st_i), .mux8_i(rd_i),
    .out_valid_o(a_ov), .out_ready_i(out_r), .WB_o(a_wb), .ALUOut_o(a_alu),
    .mux7_o(a_st), .mux8_o(a_rd), .MemRead_o(a_mr),
`ifdef EX_MEM_FWD_EN
    .MemWrite_o(a_mw), .fwd_valid_o(a_fv), .fwd_rd_o(a_frd), .fwd_data_o(a_fd)
`else
    .MemWrite_o(a_mw)
`endif
  );

  ex_mem_stage_reg #(.DATA_W(32), .REG_W(5), .SKID(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_v), .in_ready_o(b_ir),
    .WB_i(wb_i), .MEM_i(mem_i), .ALUOut_i(alu_i), .mux7_i(st_i), .mux8_i(rd_i),
    .out_valid_o(b_ov), .out_ready_i(out_r), .WB_o(b_wb), .ALUOut_o(b_alu),
    .mux7_o(b_st), .mux8_o(b_rd), .MemRead_o(b_mr),
`ifdef EX_MEM_FWD_EN
    .MemWrite_o(b_mw), .fwd_valid_o(b_fv), .fwd_rd_o(b_frd), .fwd_data_o(b_fd)
`else
    .MemWrite_o(b_mw)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [1:0] wb, input logic [1:0] mem,
                              input logic [31:0] alu, input logic [31:0] st,
                              input logic [4:0] rd);
    ent_t e;
    e.wb = wb; e.mem = mem; e.alu = alu; e.st = st; e.rd = rd;
    return e;
  endfunction

  // Compare one instance's outputs with the model's head entry.
  task automatic cmp_dut(input string p, input int sz, input ent_t hd, input logic exp_rdy,
                         input logic ov, input logic ir, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rd,
                         input logic mr, input logic mw);
    chk({p, ".out_valid"}, 64'(ov), 64'(sz > 0));
    chk({p, ".in_ready"}, 64'(ir), 64'(exp_rdy));
    if (sz > 0) begin
      chk({p, ".WB"}, 64'(wb), 64'(hd.wb));
      chk({p, ".ALUOut"}, 64'(alu), 64'(hd.alu));
      chk({p, ".mux7"}, 64'(st), 64'(hd.st));
      chk({p, ".mux8"}, 64'(rd), 64'(hd.rd));
      chk({p, ".MemRead"}, 64'(mr), 64'(hd.mem[0]));
      chk({p, ".MemWrite"}, 64'(mw), 64'(hd.mem[1]));
    end else begin
      chk({p, ".MemRead_idle"}, 64'(mr), 64'd0);
      chk({p, ".MemWrite_idle"}, 64'(mw), 64'd0);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the models.
  task automatic step(input logic v, input logic ordy, input logic fl, input ent_t e);
    logic ra, rb;
    ent_t ha, hb;
    @(negedge clk);
    in_v = v; out_r = ordy; flush = fl;
    wb_i = e.wb; mem_i = e.mem; alu_i = e.alu; st_i = e.st; rd_i = e.rd;
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || ordy;
    ha = (qa.size() > 0) ? qa[0] : '0;
    hb = (qb.size() > 0) ? qb[0] : '0;
    cmp_dut("skid1", qa.size(), ha, ra, a_ov, a_ir, a_wb, a_alu, a_st, a_rd, a_mr, a_mw);
    cmp_dut("skid0", qb.size(), hb, rb, b_ov, b_ir, b_wb, b_alu, b_st, b_rd, b_mr, b_mw);
`ifdef EX_MEM_FWD_EN
    chk("fwd_valid", 64'(a_fv),
        64'((qa.size() > 0) && ha.wb == 2'b01 && ha.rd != 5'd0));
    if (qa.size() > 0) begin
      chk("fwd_rd", 64'(a_frd), 64'(ha.rd));
      chk("fwd_data", 64'(a_fd), 64'(ha.alu));
    end
`endif
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && ordy) void'(qa.pop_front());
      if (v && ra) qa.push_back(e);
      if (qb.size() > 0 && ordy) void'(qb.pop_front());
      if (v && rb) qb.push_back(e);
    end
  endtask

  // Assert reset asynchronously between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    in_v = 1'b1; out_r = 1'b0; mem_i = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.a_out_valid", 64'(a_ov), 64'd0);
    chk("rst.a_in_ready", 64'(a_ir), 64'd1);
    chk("rst.a_mem", 64'({a_mr, a_mw, a_wb, a_alu != 0, a_st != 0, a_rd != 0}), 64'd0);
    chk("rst.b_out_valid", 64'(b_ov), 64'd0);
    chk("rst.b_in_ready", 64'(b_ir), 64'd1);
    chk("rst.b_mem", 64'({b_mr, b_mw}), 64'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_v = 1'b0;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.wb  = 2'($urandom);
    e.mem = 2'($urandom);
    e.alu = $urandom;
    e.st  = $urandom;
    e.rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    return e;
  endfunction

  initial begin
    #3;
    chk("init.out_valid", 64'(a_ov), 64'd0);
    chk("init.in_ready", 64'(a_ir), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: back-to-back with MEM always ready.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'(i * 16), 32'h0, 5'(i)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Stall: A, B held; C offered until taken, then drain.
    step(1'b1, 1'b0, 1'b0, mk(2'b00, 2'b10, 32'h11, 32'hA, 5'd1));
    step(1'b1, 1'b0, 1'b0, mk(2'b00, 2'b10, 32'h22, 32'hB, 5'd2));
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, mk(2'b00, 2'b01, 32'h33, 32'hC, 5'd3));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, mk(2'b00, 2'b01, 32'h33, 32'hC, 5'd3));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Flush with two held entries and a same-cycle input.
    step(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b01, 32'h44, 32'h1, 5'd4));
    step(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b01, 32'h45, 32'h2, 5'd5));
    step(1'b1, 1'b0, 1'b1, mk(2'b01, 2'b01, 32'h46, 32'h3, 5'd6));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Decode gating: MEM=11 offered while invalid, then held valid.
    step(1'b0, 1'b0, 1'b0, mk(2'b00, 2'b11, 32'h77, 32'h7, 5'd7));
    step(1'b1, 1'b0, 1'b0, mk(2'b00, 2'b11, 32'h77, 32'h7, 5'd7));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Forwarding qualifiers: plain writeback, rd=0, and load writeback.
    step(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'h55, 32'h0, 5'd8));
    step(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'h55, 32'h0, 5'd0));
    step(1'b1, 1'b1, 1'b0, mk(2'b11, 2'b01, 32'h55, 32'h0, 5'd8));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) < 3),
           1'($urandom_range(0, 19) == 0), rnd_ent());
    end
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
